// File: rtl/wb_select_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_select_pipe
// Description : Registered N-source write-back selector with a two-entry skid
//               buffer and valid/ready handshake for the register-file port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module wb_select_pipe #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int ADDR_W  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [SEL_W-1:0]         Sel,
    input  logic [NUM_SRC*WIDTH-1:0] SrcData,
    input  logic [ADDR_W-1:0]        WAddrIn,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         WData,
    output logic [ADDR_W-1:0]        WAddr,
    output logic                     SelErr,
    input  logic                     ErrClr
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                r_sel_err;
    logic [WIDTH-1:0]    r_main_data;
    logic [ADDR_W-1:0]   r_main_addr;
    logic [WIDTH-1:0]    r_skid_data;
    logic [ADDR_W-1:0]   r_skid_addr;

    logic                w_accept;
    logic                w_xfer;
    logic                w_bad_sel;
    logic [WIDTH-1:0]    w_sel_data;

    assign w_accept  = InValid & r_in_ready;
    assign w_xfer    = r_out_valid & OutReady;
    assign w_bad_sel = (int'(Sel) >= NUM_SRC);

    // Out-of-range selects match no source and therefore carry zero data.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(Sel) == k) begin
                w_sel_data = SrcData[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
            r_main_data <= '0;
            r_main_addr <= '0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
        end else begin
            if (w_accept && w_bad_sel) begin
                r_sel_err <= 1'b1;
            end else if (ErrClr) begin
                r_sel_err <= 1'b0;
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= w_sel_data;
                        r_main_addr <= WAddrIn;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_xfer) begin
                        r_main_data <= w_sel_data;
                        r_main_addr <= WAddrIn;
                    end else if (w_accept) begin
                        // Output is stalled: park the new entry behind it.
                        r_skid_data <= w_sel_data;
                        r_skid_addr <= WAddrIn;
                        r_state     <= S_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_xfer) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_xfer) begin
                        r_main_data <= r_skid_data;
                        r_main_addr <= r_skid_addr;
                        r_state     <= S_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign InReady  = r_in_ready;
    assign OutValid = r_out_valid;
    assign WData    = r_main_data;
    assign WAddr    = r_main_addr;
    assign SelErr   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_wb_select_pipe
// Description : Directed self-checking bench for wb_select_pipe (NUM_SRC=3).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_wb_select_pipe;

    localparam int WIDTH   = 16;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int ADDR_W  = 4;

    logic                     Clk;
    logic                     Reset_n;
    logic                     InValid;
    logic                     InReady;
    logic [SEL_W-1:0]         Sel;
    logic [NUM_SRC*WIDTH-1:0] SrcData;
    logic [ADDR_W-1:0]        WAddrIn;
    logic                     OutValid;
    logic                     OutReady;
    logic [WIDTH-1:0]         WData;
    logic [ADDR_W-1:0]        WAddr;
    logic                     SelErr;
    logic                     ErrClr;

    int checks   = 0;
    int failures = 0;

    wb_select_pipe #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .ADDR_W  (ADDR_W)
    ) u_dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sel      (Sel),
        .SrcData  (SrcData),
        .WAddrIn  (WAddrIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .WData    (WData),
        .WAddr    (WAddr),
        .SelErr   (SelErr),
        .ErrClr   (ErrClr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                             input logic [ADDR_W-1:0] a);
        check({tag, ".valid"}, 64'(OutValid), 64'(v));
        check({tag, ".data"},  64'(WData),    64'(d));
        check({tag, ".addr"},  64'(WAddr),    64'(a));
    endtask

    // Outputs must hold steady across any edge where OutValid=1 and OutReady=0.
    logic                     r_hold;
    logic [WIDTH+ADDR_W:0]    r_snap;
    initial r_hold = 1'b0;
    always @(negedge Clk) begin
        if (r_hold) begin
            check("hold_stable", 64'({OutValid, WData, WAddr}), 64'(r_snap));
        end
        r_hold = Reset_n && OutValid && !OutReady;
        r_snap = {OutValid, WData, WAddr};
    end

    logic [WIDTH-1:0]  exp_d [3];
    logic [ADDR_W-1:0] exp_a [3];

    initial begin
        Reset_n  = 1'b0;
        InValid  = 1'b1;
        Sel      = 2'd0;
        WAddrIn  = 4'd9;
        OutReady = 1'b0;
        ErrClr   = 1'b0;
        SrcData  = {16'h0002, 16'hBEEF, 16'h1234};

        // Reset held two cycles with a request pending
        step();
        step();
        check_out("rst", 1'b0, 16'h0000, 4'd0);
        check("rst.selerr",  64'(SelErr),  64'd0);
        check("rst.inready", 64'(InReady), 64'd1);

        // First accept after release shows up one cycle later
        Reset_n = 1'b1;
        WAddrIn = 4'd7;
        step();
        check_out("first", 1'b1, 16'h1234, 4'd7);
        InValid  = 1'b0;
        OutReady = 1'b1;
        step();
        check("first.drain", 64'(OutValid), 64'd0);

        // Back-to-back selects, no bubbles
        exp_d[0] = 16'h1234; exp_a[0] = 4'd1;
        exp_d[1] = 16'hBEEF; exp_a[1] = 4'd2;
        exp_d[2] = 16'h0002; exp_a[2] = 4'd3;
        InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Sel     = SEL_W'(i);
            WAddrIn = ADDR_W'(i + 1);
            step();
            check_out($sformatf("basic%0d", i), 1'b1, exp_d[i], exp_a[i]);
            check($sformatf("basic%0d.inready", i), 64'(InReady), 64'd1);
        end
        InValid = 1'b0;
        step();
        check("basic.drain", 64'(OutValid), 64'd0);

        // Stall: A and B fill main and skid, C waits upstream
        SrcData  = {16'h0033, 16'h0022, 16'h0011};
        OutReady = 1'b0;
        InValid  = 1'b1;
        Sel = 2'd0; WAddrIn = 4'd4;
        step();
        check_out("stallA", 1'b1, 16'h0011, 4'd4);
        check("stallA.inready", 64'(InReady), 64'd1);
        Sel = 2'd1; WAddrIn = 4'd5;
        step();
        check_out("stallB", 1'b1, 16'h0011, 4'd4);
        check("stallB.inready", 64'(InReady), 64'd0);
        Sel = 2'd2; WAddrIn = 4'd6;
        step();
        check_out("stallC", 1'b1, 16'h0011, 4'd4);
        check("stallC.inready", 64'(InReady), 64'd0);
        OutReady = 1'b1;
        step();
        check_out("drainB", 1'b1, 16'h0022, 4'd5);
        step();
        check_out("drainC", 1'b1, 16'h0033, 4'd6);
        InValid = 1'b0;
        step();
        check("drain.empty", 64'(OutValid), 64'd0);

        // Bad select on a three-source build
        InValid = 1'b1;
        Sel = 2'd3; WAddrIn = 4'd5;
        step();
        check_out("bad", 1'b1, 16'h0000, 4'd5);
        check("bad.selerr", 64'(SelErr), 64'd1);
        ErrClr = 1'b1;
        WAddrIn = 4'd8;
        step();
        check("bad.setwins", 64'(SelErr), 64'd1);
        check_out("bad2", 1'b1, 16'h0000, 4'd8);
        InValid = 1'b0;
        step();
        check("bad.clear", 64'(SelErr), 64'd0);
        ErrClr = 1'b0;
        step();
        check("bad.empty", 64'(OutValid), 64'd0);

        // Reset while both entries are held
        OutReady = 1'b0;
        InValid  = 1'b1;
        Sel = 2'd1; WAddrIn = 4'd10;
        step();
        Sel = 2'd2; WAddrIn = 4'd11;
        step();
        check("mid.two", 64'(InReady), 64'd0);
        Reset_n = 1'b0;
        InValid = 1'b0;
        step();
        check_out("mid.rst", 1'b0, 16'h0000, 4'd0);
        check("mid.inready", 64'(InReady), 64'd1);
        Reset_n  = 1'b1;
        OutReady = 1'b1;
        step();
        check("mid.nostale1", 64'(OutValid), 64'd0);
        step();
        check("mid.nostale2", 64'(OutValid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
